// File: rtl/dmem_resp_pkg.sv
// Shared types, widths and the address range helper for the data-memory responder.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_resp_state_e;

    localparam int unsigned WAIT_CNT_W = 4;
    // Range check is done wide enough that BaseAddr + 4*Depth can never overflow.
    localparam int unsigned RANGE_W    = 64;

    // True when base <= addr < base + 4*depth (byte address, word-sized bank).
    function automatic logic in_range(input logic [RANGE_W-1:0] addr,
                                      input logic [RANGE_W-1:0] base,
                                      input logic [RANGE_W-1:0] depth);
        return (addr >= base) && ((addr - base) < (depth << 2));
    endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// Single-port word array: synchronous write, synchronous registered read.
// The read register clears on writes and error responses so it can drive
// the response data output directly.
module dmem_sram_bank #(
    parameter int unsigned DWidth   = 32,
    parameter int unsigned Depth    = 4096,
    parameter int unsigned AW       = 12,
    parameter string       InitFile = ""
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [AW-1:0]     addr,
    input  logic [DWidth-1:0] wdata,
    output logic [DWidth-1:0] rdata
);

    logic [DWidth-1:0] mem [Depth];
    logic [DWidth-1:0] rdata_d;
    logic [DWidth-1:0] rdata_q;

    // Array write port.
    always_ff @(posedge clk_i) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Next read-register value: load on read, zero on write or error.
    always_comb begin
        rdata_d = rdata_q;
        if (clr) begin
            rdata_d = '0;
        end else if (en) begin
            rdata_d = we ? '0 : mem[addr];
        end
    end

    // Read data register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_resp_bank.sv
// Data-memory responder for the core dmem request/ready port with a fixed
// number of wait states before a one-cycle ready strobe.
// Optional access counters: define DMEM_RESP_ACCESS_CNT_EN.
module dmem_resp_bank
    import dmem_resp_pkg::*;
#(
    parameter int unsigned       DWidth     = 32,
    parameter logic [DWidth-1:0] BaseAddr   = DWidth'(32'h0000_4000),
    parameter int unsigned       Depth      = 4096,
    parameter int unsigned       WaitCycles = 2,
    parameter string             InitFile   = ""
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dmem_req_i,
    input  logic              dmem_write_i,
    input  logic [DWidth-1:0] dmem_addr_i,
    input  logic [DWidth-1:0] dmem_wdata_i,
    output logic              dmem_ready_o,
    output logic [DWidth-1:0] dmem_rdata_o,
    output logic              dmem_err_o
`ifdef DMEM_RESP_ACCESS_CNT_EN
    ,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
`endif
);

    localparam int unsigned          AW       = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [WAIT_CNT_W-1:0] WaitLd  = WAIT_CNT_W'(WaitCycles);
    localparam bit                   ZeroWait = (WaitCycles == 0);

    dmem_resp_state_e        state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic                    ok_q, ok_d;
    logic [AW-1:0]           off_q, off_d;
    logic [DWidth-1:0]       wdata_q, wdata_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;

    logic                    in_rng_c;
    logic [AW-1:0]           off_in_c;
    logic                    resp_go_c;
    logic                    acc_wr_c;
    logic                    acc_ok_c;
    logic [AW-1:0]           acc_off_c;
    logic [DWidth-1:0]       acc_wdata_c;
    logic                    bank_en_c;
    logic                    bank_clr_c;

    // Decode of the live request: range check and word offset.
    assign in_rng_c = in_range(RANGE_W'(dmem_addr_i), RANGE_W'(BaseAddr), RANGE_W'(Depth));
    assign off_in_c = AW'((dmem_addr_i - BaseAddr) >> 2);

    // Next-state, latch and response decode; the access fields come from the
    // live inputs only when zero wait states send IDLE straight to RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        ok_d        = ok_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        ready_d     = 1'b0;
        err_d       = err_q;
        resp_go_c   = 1'b0;
        acc_wr_c    = write_q;
        acc_ok_c    = ok_q;
        acc_off_c   = off_q;
        acc_wdata_c = wdata_q;

        case (state_q)
            IDLE: begin
                if (dmem_req_i) begin
                    write_d = dmem_write_i;
                    ok_d    = in_rng_c;
                    off_d   = off_in_c;
                    wdata_d = dmem_wdata_i;
                    if (ZeroWait) begin
                        state_d     = RESP;
                        resp_go_c   = 1'b1;
                        acc_wr_c    = dmem_write_i;
                        acc_ok_c    = in_rng_c;
                        acc_off_c   = off_in_c;
                        acc_wdata_c = dmem_wdata_i;
                    end else begin
                        cnt_d   = WaitLd;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_CNT_W'(1)) begin
                    cnt_d     = '0;
                    state_d   = RESP;
                    resp_go_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (resp_go_c) begin
            ready_d = 1'b1;
            err_d   = ~acc_ok_c;
        end
    end

    // Bank strobes fire only on the edge entering RESP, and never under reset.
    assign bank_en_c  = resp_go_c & acc_ok_c & ~rst_i;
    assign bank_clr_c = resp_go_c & ~acc_ok_c;

    // FSM, latched request and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            ok_q    <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            ok_q    <= ok_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    dmem_sram_bank #(
        .DWidth   (DWidth),
        .Depth    (Depth),
        .AW       (AW),
        .InitFile (InitFile)
    ) u_bank (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (bank_en_c),
        .we    (acc_wr_c),
        .clr   (bank_clr_c),
        .addr  (acc_off_c),
        .wdata (acc_wdata_c),
        .rdata (dmem_rdata_o)
    );

    assign dmem_ready_o = ready_q;
    assign dmem_err_o   = err_q;

`ifdef DMEM_RESP_ACCESS_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Count successful reads and writes as they enter RESP; errors are not counted.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (resp_go_c && acc_ok_c) begin
            if (acc_wr_c) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 32'd1;
            end
        end
    end

    // Access counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_resp_bank.sv
// Bench for dmem_resp_bank: one instance with two wait states, one with none.
module tb_dmem_resp_bank;

    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic [31:0] rdata [2];
    logic        err   [2];
`ifdef DMEM_RESP_ACCESS_CNT_EN
    logic [31:0] rdc [2];
    logic [31:0] wrc [2];
`endif

    always #5 clk = ~clk;

    dmem_resp_bank #(.DWidth(32), .BaseAddr(BASE), .Depth(DEPTH), .WaitCycles(2)) u_w2 (
        .clk_i(clk), .rst_i(rst), .dmem_req_i(req[0]), .dmem_write_i(wr[0]),
        .dmem_addr_i(addr[0]), .dmem_wdata_i(wdata[0]), .dmem_ready_o(ready[0]),
        .dmem_rdata_o(rdata[0]), .dmem_err_o(err[0])
`ifdef DMEM_RESP_ACCESS_CNT_EN
        , .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0])
`endif
    );

    dmem_resp_bank #(.DWidth(32), .BaseAddr(BASE), .Depth(DEPTH), .WaitCycles(0)) u_w0 (
        .clk_i(clk), .rst_i(rst), .dmem_req_i(req[1]), .dmem_write_i(wr[1]),
        .dmem_addr_i(addr[1]), .dmem_wdata_i(wdata[1]), .dmem_ready_o(ready[1]),
        .dmem_rdata_o(rdata[1]), .dmem_err_o(err[1])
`ifdef DMEM_RESP_ACCESS_CNT_EN
        , .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1])
`endif
    );

    localparam int WAITS [2] = '{2, 0};

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: word-addressed bank with access counters.
    logic [31:0] mdl   [2][DEPTH];
    int unsigned m_rd  [2];
    int unsigned m_wr  [2];

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          exp_er;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic model(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output bit er);
        longint unsigned a64;
        int idx;
        a64 = 64'(a);
        rd  = '0;
        er  = 1'b0;
        if (a64 >= 64'(BASE) && a64 < 64'(BASE) + 64'(4 * DEPTH)) begin
            idx = int'((a - BASE) / 4);
            if (w) begin
                mdl[u][idx] = d;
                m_wr[u]++;
            end else begin
                rd = mdl[u][idx];
                m_rd[u]++;
            end
        end else begin
            er = 1'b1;
        end
    endtask

    // Drive one request and wait (bounded) for ready; optionally check the strobe
    // is one cycle wide and that data/err hold afterwards.
    task automatic access(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit pulse, output logic [31:0] rd, output bit er, output int lat);
        bit got;
        got      = 1'b0;
        req[u]   = 1'b1;
        wr[u]    = w;
        addr[u]  = a;
        wdata[u] = d;
        lat      = 0;
        rd       = '0;
        er       = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready[u]) begin
                got = 1'b1;
                rd  = rdata[u];
                er  = err[u];
            end
        end
        req[u] = 1'b0;
        check($sformatf("u%0d ready seen", u), 64'(got), 64'd1);
        if (pulse && got) begin
            @(posedge clk);
            #1;
            check($sformatf("u%0d ready width", u), 64'(ready[u]), 64'd0);
            check($sformatf("u%0d rdata hold", u), 64'(rdata[u]), 64'(rd));
            check($sformatf("u%0d err hold", u), 64'(err[u]), 64'(er));
        end
    endtask

    // Model-predicted access with data, error and latency checks.
    task automatic xact(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit pulse, input int exp_lat, input string nm);
        logic [31:0] e_rd, g_rd;
        bit e_er, g_er;
        int lat;
        model(u, w, a, d, e_rd, e_er);
        access(u, w, a, d, pulse, g_rd, g_er, lat);
        check({nm, " rdata"}, 64'(g_rd), 64'(e_rd));
        check({nm, " err"}, 64'(g_er), 64'(e_er));
        check({nm, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        logic [31:0] g_rd, prior;
        bit g_er, e_er;
        int lat, n;
        bit got;
        logic [31:0] e_rd;

        tbl[0]  = '{1'b1, 32'h0000_4010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h0000_4010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_4000, 32'h1111_1111, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 32'h0000_3FFC, 32'h1234_5678, 32'h0,         1'b1};
        tbl[4]  = '{1'b0, 32'h0000_4000, 32'h0,         32'h1111_1111, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_4040, 32'h0,         32'h0,         1'b1};
        tbl[6]  = '{1'b1, 32'h0000_403F, 32'hCAFE_F00D, 32'h0,         1'b0};
        tbl[7]  = '{1'b0, 32'h0000_403C, 32'h0,         32'hCAFE_F00D, 1'b0};
        tbl[8]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1};
        tbl[9]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};
        tbl[10] = '{1'b1, 32'h0000_4002, 32'h0BAD_F00D, 32'h0,         1'b0};
        tbl[11] = '{1'b0, 32'h0000_4000, 32'h0,         32'h0BAD_F00D, 1'b0};

        for (int u = 0; u < 2; u++) begin
            req[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
            m_rd[u] = 0; m_wr[u] = 0;
        end

        // Reset held for 3 cycles with a request pending.
        rst     = 1'b1;
        req[0]  = 1'b1;
        addr[0] = BASE;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset ready", 64'(ready[0]), 64'd0);
            check("reset rdata", 64'(rdata[0]), 64'd0);
            check("reset err", 64'(err[0]), 64'd0);
        end
        rst = 1'b0;
        access(0, 1'b0, BASE, 32'h0, 1'b1, g_rd, g_er, lat);
        check("post-reset latency", 64'(lat), 64'd3);
        check("post-reset err", 64'(g_er), 64'd0);

        // Known contents in both banks.
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < DEPTH; i++)
                xact(u, 1'b1, BASE + 32'(4 * i), 32'hA000_0000 | (32'(i) * 32'h0101), 1'b1,
                     WAITS[u] + 1, "init write");

        // Directed vectors on the two-wait-state instance.
        for (int i = 0; i < 12; i++) begin
            model(0, tbl[i].w, tbl[i].a, tbl[i].d, e_rd, e_er);
            access(0, tbl[i].w, tbl[i].a, tbl[i].d, 1'b1, g_rd, g_er, lat);
            check($sformatf("vec%0d rdata", i), 64'(g_rd), 64'(tbl[i].exp_rd));
            check($sformatf("vec%0d err", i), 64'(g_er), 64'(tbl[i].exp_er));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd3);
        end

        // Reset on the edge that would enter RESP for a write: write is dropped.
        prior    = mdl[0][8];
        req[0]   = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_4020; wdata[0] = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst    = 1'b1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("rst mid-write ready", 64'(ready[0]), 64'd0);
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin m_rd[u] = 0; m_wr[u] = 0; end
        @(posedge clk); #1;
        check("rst mid-write ready later", 64'(ready[0]), 64'd0);
        access(0, 1'b0, 32'h0000_4020, 32'h0, 1'b1, g_rd, g_er, lat);
        check("rst mid-write contents", 64'(g_rd), 64'(prior));
        m_rd[0]++;

        // Inputs changed mid-transaction are ignored.
        model(0, 1'b1, 32'h0000_4004, 32'h7777_7777, e_rd, e_er);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_4004; wdata[0] = 32'h7777_7777;
        @(posedge clk); #1;
        wr[0] = 1'b0; addr[0] = 32'h0000_4008; wdata[0] = 32'h0;
        got = 1'b0;
        n   = 1;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            got = ready[0];
        end
        req[0] = 1'b0;
        check("violation ready latency", 64'(n), 64'd3);
        @(posedge clk); #1;
        xact(0, 1'b0, 32'h0000_4004, 32'h0, 1'b1, 3, "violation latched addr");
        xact(0, 1'b0, 32'h0000_4008, 32'h0, 1'b1, 3, "violation other addr");

        // Zero wait states: back-to-back reads, ready every 2nd cycle.
        xact(1, 1'b0, 32'h0000_4000, 32'h0, 1'b0, 1, "zw read0");
        xact(1, 1'b0, 32'h0000_4004, 32'h0, 1'b0, 2, "zw read1");
        xact(1, 1'b0, 32'h0000_4008, 32'h0, 1'b0, 2, "zw read2");
        xact(1, 1'b0, 32'h0000_400C, 32'h0, 1'b1, 2, "zw read3");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            int u, r;
            logic [31:0] a;
            u = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = BASE + 32'($urandom_range(0, 63));
            else if (r == 7) a = BASE - 32'($urandom_range(1, 64));
            else if (r == 8) a = BASE + 32'h40 + 32'($urandom_range(0, 64));
            else             a = $urandom;
            xact(u, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, WAITS[u] + 1,
                 $sformatf("rand%0d u%0d", i, u));
        end

`ifdef DMEM_RESP_ACCESS_CNT_EN
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d rd_cnt", u), 64'(rdc[u]), 64'(m_rd[u]));
            check($sformatf("u%0d wr_cnt", u), 64'(wrc[u]), 64'(m_wr[u]));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
